// File: rtl/fft_bitrev_loader_if.sv
// rtl/fft_bitrev_loader_if.sv - sample-in / buffer-write / buffer-read bundle for fft_bitrev_loader
//
// Purpose: groups the loader's handshake and buffer-side signals.
// Signals:
//   in_valid, Re_in, Im_in            : input sample stream (producer -> loader)
//   in_ready                          : loader accepts a sample this cycle
//   load_data, invert_adr, Re_o, Im_o : buffer write strobe, bit-reversed address, write data
//   en_rd, rd_ptr, rd_angle_ptr       : buffer read enable, read address, twiddle select
//   frame_done, busy                  : end-of-frame pulse, READ-state indicator
// Modports: slave = loader side, master = producer/consumer side.
interface fft_bitrev_loader_if #(
  parameter int bit_width = 29,
  parameter int SIZE      = 4
);
  logic                        in_valid;
  logic signed [bit_width-1:0] Re_in;
  logic signed [bit_width-1:0] Im_in;
  logic                        in_ready;
  logic                        load_data;
  logic [SIZE-1:0]             invert_adr;
  logic signed [bit_width-1:0] Re_o;
  logic signed [bit_width-1:0] Im_o;
  logic                        en_rd;
  logic [SIZE-1:0]             rd_ptr;
  logic                        rd_angle_ptr;
  logic                        frame_done;
  logic                        busy;

  modport slave (
    input  in_valid, Re_in, Im_in,
    output in_ready, load_data, invert_adr, Re_o, Im_o,
           en_rd, rd_ptr, rd_angle_ptr, frame_done, busy
  );

  modport master (
    output in_valid, Re_in, Im_in,
    input  in_ready, load_data, invert_adr, Re_o, Im_o,
           en_rd, rd_ptr, rd_angle_ptr, frame_done, busy
  );
endinterface

// File: rtl/fft_bitrev_loader.sv
// rtl/fft_bitrev_loader.sv - FFT input loader: bit-reversed buffer writes, radix-2 paired read-out
//
// Purpose: accepts N complex samples, writes each to the frame buffer at the
// bit-reversed index of its arrival order, then reads the buffer back N cycles
// in the order g+0, g+2, g+1, g+3 per group of four with a twiddle select.
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : fft_bitrev_loader_if.slave (sample input, buffer write, buffer read, status)
//   ovf_err      : only with LOADER_OVF_ERR_EN defined; sticky flag, set when a
//                  sample is offered while in_ready is low, cleared only by reset
// Configuration macro: LOADER_OVF_ERR_EN
module fft_bitrev_loader #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_bitrev_loader_if.slave bus
`ifdef LOADER_OVF_ERR_EN
  ,
  output logic               ovf_err
`endif
);

  typedef enum logic {LOAD, READ} state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] wr_cnt;
  // rd_cnt = 0 is the settle cycle that lets the last write land; 1..N are reads.
  logic [SIZE:0]   rd_cnt;
  logic [SIZE:0]   rd_cnt_m1;
  logic [SIZE-1:0] rd_idx;
  logic            accept;
  logic            rd_last;

  function automatic logic [SIZE-1:0] bit_rev(input logic [SIZE-1:0] a);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = a[SIZE-1-i];
    end
    return r;
  endfunction

  assign rd_cnt_m1 = rd_cnt - {{SIZE{1'b0}}, 1'b1};
  assign rd_idx    = rd_cnt_m1[SIZE-1:0];
  assign rd_last   = (rd_cnt == (SIZE+1)'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.in_ready     = 1'b0;
    bus.busy         = 1'b0;
    bus.en_rd        = 1'b0;
    bus.rd_ptr       = '0;
    bus.rd_angle_ptr = 1'b0;
    accept           = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (accept && (wr_cnt == SIZE'(N - 1))) begin
          state_nxt = READ;
        end
      end
      READ: begin
        bus.busy = 1'b1;
        if (rd_cnt != '0) begin
          bus.en_rd = 1'b1;
          // Swapping the two low index bits yields g+0, g+2, g+1, g+3;
          // the odd member of each butterfly pair takes the -j twiddle.
          bus.rd_ptr       = {rd_idx[SIZE-1:2], rd_idx[0], rd_idx[1]};
          bus.rd_angle_ptr = rd_idx[1];
        end
        if (rd_last) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt         <= '0;
      rd_cnt         <= '0;
      bus.load_data  <= 1'b0;
      bus.invert_adr <= '0;
      bus.Re_o       <= '0;
      bus.Im_o       <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.load_data  <= accept;
      bus.frame_done <= (state == READ) && rd_last;
      if (accept) begin
        bus.invert_adr <= bit_rev(wr_cnt);
        bus.Re_o       <= bus.Re_in;
        bus.Im_o       <= bus.Im_in;
        wr_cnt         <= wr_cnt + 1'b1;
      end
      if (state == READ && !rd_last) begin
        rd_cnt <= rd_cnt + 1'b1;
      end else begin
        rd_cnt <= '0;
      end
    end
  end

`ifdef LOADER_OVF_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (bus.in_valid && !bus.in_ready) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// tb/tb_fft_bitrev_loader.sv - self-checking bench for fft_bitrev_loader
module tb_fft_bitrev_loader;
  localparam int BW   = 29;
  localparam int N    = 16;
  localparam int SIZE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_bitrev_loader_if #(.bit_width(BW), .SIZE(SIZE)) bus ();

`ifdef LOADER_OVF_ERR_EN
  logic ovf_err;
  fft_bitrev_loader #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ovf_err(ovf_err));
`else
  fft_bitrev_loader #(.bit_width(BW), .N(N), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame timeline relative to the cycle of the Nth acceptance.
  int cyc = 0;
  int t_end = -1000;
  int m_cnt = 0;
  bit prev_acc = 0;
  bit m_ovf = 0;
  logic [63:0] last_addr = 0;
  logic signed [BW-1:0] last_re = 0;
  logic signed [BW-1:0] last_im = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_bitrev(input int i);
    int r = 0;
    int x = i;
    for (int b = 0; b < SIZE; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int ref_rdptr(input int k);
    int p = k % 4;
    int off = (p == 1) ? 2 : (p == 2) ? 1 : p;
    return (k / 4) * 4 + off;
  endfunction

  task automatic cycle(input bit v, input logic signed [BW-1:0] re, input logic signed [BW-1:0] im);
    bit exp_busy, exp_rd, exp_fd, exp_ir, acc;
    int k;
    @(negedge clk);
    bus.in_valid = v;
    bus.Re_in = re;
    bus.Im_in = im;
    #1;
    exp_busy = (cyc >= t_end + 1) && (cyc <= t_end + 1 + N);
    exp_rd   = (cyc >= t_end + 2) && (cyc <= t_end + 1 + N);
    exp_fd   = (cyc == t_end + 2 + N);
    exp_ir   = !exp_busy;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    chk("en_rd", 64'(bus.en_rd), 64'(exp_rd));
    chk("frame_done", 64'(bus.frame_done), 64'(exp_fd));
    chk("load_data", 64'(bus.load_data), 64'(prev_acc));
    chk("invert_adr", 64'(bus.invert_adr), last_addr);
    chk("Re_o", 64'(bus.Re_o), 64'(last_re));
    chk("Im_o", 64'(bus.Im_o), 64'(last_im));
    if (exp_rd) begin
      k = cyc - t_end - 2;
      chk("rd_ptr", 64'(bus.rd_ptr), 64'(ref_rdptr(k)));
      chk("rd_angle_ptr", 64'(bus.rd_angle_ptr), 64'((k % 4) >= 2));
    end
`ifdef LOADER_OVF_ERR_EN
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
`endif
    acc = v && exp_ir;
    if (v && !exp_ir) m_ovf = 1;
    @(posedge clk);
    prev_acc = acc;
    if (acc) begin
      last_addr = 64'(ref_bitrev(m_cnt));
      last_re = re;
      last_im = im;
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt = 0;
        t_end = cyc;
      end
    end
    cyc++;
  endtask

  task automatic rnd_cycle(input bit v);
    cycle(v, BW'($urandom), BW'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_load_data", 64'(bus.load_data), 64'd0);
    chk("rst_en_rd", 64'(bus.en_rd), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_invert_adr", 64'(bus.invert_adr), 64'd0);
    chk("rst_rd_ptr", 64'(bus.rd_ptr), 64'd0);
    chk("rst_rd_angle_ptr", 64'(bus.rd_angle_ptr), 64'd0);
    chk("rst_Re_o", 64'(bus.Re_o), 64'd0);
    chk("rst_Im_o", 64'(bus.Im_o), 64'd0);
`ifdef LOADER_OVF_ERR_EN
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t_end = -1000;
    m_cnt = 0;
    prev_acc = 0;
    m_ovf = 0;
    last_addr = 0;
    last_re = 0;
    last_im = 0;
    cyc++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.Re_in = '0;
    bus.Im_in = '0;
    do_reset();

    // Back-to-back frame with Re = 0..15, then idle through READ.
    for (int i = 0; i < N; i++) cycle(1'b1, BW'(i), BW'($urandom));
    for (int i = 0; i < N + 4; i++) rnd_cycle(1'b0);

    // in_valid toggling every cycle.
    for (int i = 0; i < 2 * N - 1; i++) rnd_cycle((i % 2) == 0);
    // in_valid held high through READ and into the next frame.
    for (int i = 0; i < N + 6; i++) rnd_cycle(1'b1);

    // Random gaps.
    for (int i = 0; i < 80; i++) rnd_cycle(1'($urandom_range(0, 1)));

    // Partial frame discarded by reset, then a full frame and its read-out.
    do_reset();
    for (int i = 0; i < 7; i++) rnd_cycle(1'b1);
    do_reset();
    for (int i = 0; i < N; i++) rnd_cycle(1'b1);
    for (int i = 0; i < N + 4; i++) rnd_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_loader.md
FFT_BITREV_LOADER -- requirements
Module: fft_bitrev_loader

Interface
REQ-001 SHALL have parameter bit_width, default 29, sample word width of Re/Im.
REQ-002 SHALL have parameter N, default 16, points per frame.
REQ-003 SHALL have parameter SIZE, default 4, address width, log2(N).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  in  1  input sample present.
REQ-007 SHALL have port Re_in, Im_in  in  bit_width signed  input sample.
REQ-008 SHALL have port in_ready  out  1  loader accepts sample this cycle.
REQ-009 SHALL have port load_data  out  1  buffer write strobe.
REQ-010 SHALL have port invert_adr  out  SIZE  bit-reversed write address.
REQ-011 SHALL have port Re_o, Im_o  out  bit_width signed  write data.
REQ-012 SHALL have port en_rd  out  1  buffer read enable.
REQ-013 SHALL have port rd_ptr  out  SIZE  buffer read address.
REQ-014 SHALL have port rd_angle_ptr  out  1  twiddle select (0 = W^0, 1 = -j).
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse after the last read of a frame.
REQ-016 SHALL have port busy  out  1  high in READ state.

Function
REQ-017 SHALL implement FSM states LOAD and READ; reset enters LOAD.
REQ-018 LOAD: in_ready = 1; a sample is accepted when in_valid && in_ready, incrementing a SIZE-bit write counter wr_cnt.
REQ-019 Per accepted sample, next cycle SHALL assert load_data = 1 with invert_adr = bit-reverse(wr_cnt at acceptance) and Re_o/Im_o = accepted sample (one-cycle registered latency); otherwise load_data = 0 and address/data hold.
REQ-020 On acceptance of the Nth sample (wr_cnt = N-1), wr_cnt SHALL wrap to 0, in_ready SHALL drop the next cycle, and FSM SHALL enter READ in the cycle the final load_data is high.
REQ-021 READ SHALL begin with en_rd = 1 in the cycle after the final load_data, so the final write is committed before the first read.
REQ-022 READ SHALL hold en_rd = 1 for exactly N consecutive cycles, with rd_ptr order per group of 4: g+0, g+2, g+1, g+3, for g = 0, 4, ..., N-4.
REQ-023 rd_angle_ptr SHALL be 0 while reading g+0/g+2 and 1 while reading g+1/g+3, aligned with rd_ptr.
REQ-024 In the cycle after the last read, frame_done SHALL pulse for 1 cycle, en_rd = 0, FSM returns to LOAD, and in_ready = 1.
REQ-025 in_valid while in_ready = 0 SHALL be ignored: no write, no counter change.
REQ-026 Gaps in in_valid during LOAD SHALL only stall; no timeout.
REQ-027 N SHALL be a power of two >= 4; SIZE = log2(N).

Reset
REQ-028 rst_n low SHALL asynchronously force state LOAD, wr_cnt = 0, read counter = 0, in_ready = 1 after release, load_data = 0, en_rd = 0, frame_done = 0, busy = 0, invert_adr = 0, rd_ptr = 0, rd_angle_ptr = 0, Re_o = Im_o = 0.
REQ-029 Reset mid-LOAD or mid-READ SHALL discard the partial frame; the first post-reset sample writes invert_adr 0.

Configuration
REQ-030 Macro LOADER_OVF_ERR_EN defined SHALL add output ovf_err (1 bit, reset 0): sticky set when in_valid = 1 and in_ready = 0; cleared only by reset.
REQ-031 Without LOADER_OVF_ERR_EN, port ovf_err SHALL not exist and behaviour is otherwise identical.

Verification
REQ-032 N=16; 16 back-to-back samples Re = 0..15 -> writes at invert_adr 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with Re_o = 0..15, one cycle after each acceptance.
REQ-033 After the 16th acceptance -> in_ready low the next cycle; en_rd high for 16 cycles with rd_ptr 0,2,1,3,4,6,5,7,8,10,9,11,12,14,13,15 and rd_angle_ptr 0,0,1,1 repeating; frame_done high 1 cycle; busy high during READ only.
REQ-034 in_valid toggled 1/0 every cycle -> 16 writes over 31 cycles, same address order, no extra strobes.
REQ-035 in_valid held high during READ -> no load_data, wr_cnt unchanged; with LOADER_OVF_ERR_EN, ovf_err = 1 and stays 1.
REQ-036 rst_n pulsed low after 7 samples, then 16 samples -> first post-reset write at invert_adr 0; a full, correct READ follows.
